// File: rtl/rvv_backend_uop_split_seq_if.sv
// Handshake bundle between the instruction source, the uop splitter and the
// downstream operand byte-type generator.
// master: instruction producer / uop consumer side.
// slave : the splitter itself.
interface rvv_backend_uop_split_seq_if #(
   parameter int VL_W     = 8,
   parameter int VSTART_W = 7,
   parameter int UIDX_W   = 3
) ();
   // instruction side
   logic                inst_valid;
   logic                inst_ready;
   logic [3:0]          inst_uop_cnt;
   logic [VL_W-1:0]     inst_vl;
   logic [VSTART_W-1:0] inst_vstart;
   logic [1:0]          inst_vs1_eew;
   logic [1:0]          inst_vs2_eew;
   logic [1:0]          inst_vd_eew;
   logic                inst_vm;
   logic                inst_ignore_vta;
   logic                inst_ignore_vma;

   // uop side
   logic                uop_valid;
   logic                uop_ready;
   logic [UIDX_W-1:0]   uop_index;
   logic                uop_last;
   logic [VL_W-1:0]     uop_vl;
   logic [VSTART_W-1:0] uop_vstart;
   logic [1:0]          uop_vs1_eew;
   logic [1:0]          uop_vs2_eew;
   logic [1:0]          uop_vd_eew;
   logic                uop_vm;
   logic                uop_ignore_vta;
   logic                uop_ignore_vma;

   modport master (
      output inst_valid, inst_uop_cnt, inst_vl, inst_vstart,
             inst_vs1_eew, inst_vs2_eew, inst_vd_eew,
             inst_vm, inst_ignore_vta, inst_ignore_vma,
      input  inst_ready,
      input  uop_valid, uop_index, uop_last, uop_vl, uop_vstart,
             uop_vs1_eew, uop_vs2_eew, uop_vd_eew,
             uop_vm, uop_ignore_vta, uop_ignore_vma,
      output uop_ready
   );

   modport slave (
      input  inst_valid, inst_uop_cnt, inst_vl, inst_vstart,
             inst_vs1_eew, inst_vs2_eew, inst_vd_eew,
             inst_vm, inst_ignore_vta, inst_ignore_vma,
      output inst_ready,
      output uop_valid, uop_index, uop_last, uop_vl, uop_vstart,
             uop_vs1_eew, uop_vs2_eew, uop_vd_eew,
             uop_vm, uop_ignore_vta, uop_ignore_vma,
      input  uop_ready
   );
endinterface

// File: rtl/rvv_backend_uop_split_seq.sv
// Sequential uop splitter: takes one decoded vector instruction per handshake
// and emits its uops one per cycle with index/last tags and the latched
// per-instruction fields. Back-to-back instructions run without a bubble;
// flush drops the in-flight instruction.
// Optional feature macro: UOP_SPLIT_VSTART_SKIP_EN -- when defined, uops that
// lie entirely below vstart are skipped (start index derived from vstart and
// the widest operand EEW). EEW codes: 0=EEW8, 1=EEW16, 2=EEW32.
module rvv_backend_uop_split_seq #(
   parameter int VLENB    = 16,
   parameter int UOP_MAX  = 8,
   parameter int VL_W     = 8,
   parameter int VSTART_W = 7,
   parameter int UIDX_W   = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic flush,
   rvv_backend_uop_split_seq_if.slave bus
);

   typedef enum logic {
      IDLE  = 1'b0,
      SPLIT = 1'b1
   } state_e;

   state_e              state_q, state_d;
   logic [UIDX_W-1:0]   uop_index_q, uop_index_d;
   logic [UIDX_W-1:0]   last_idx_q, last_idx_d;
   logic                uop_last_q, uop_last_d;
   logic [VL_W-1:0]     uop_vl_q, uop_vl_d;
   logic [VSTART_W-1:0] uop_vstart_q, uop_vstart_d;
   logic [1:0]          uop_vs1_eew_q, uop_vs1_eew_d;
   logic [1:0]          uop_vs2_eew_q, uop_vs2_eew_d;
   logic [1:0]          uop_vd_eew_q, uop_vd_eew_d;
   logic                uop_vm_q, uop_vm_d;
   logic                uop_ignore_vta_q, uop_ignore_vta_d;
   logic                uop_ignore_vma_q, uop_ignore_vma_d;

   logic                inst_ready_c;
   logic                accept;
   logic [3:0]          cnt_clamp;
   logic [UIDX_W-1:0]   last_idx_new;
   logic [UIDX_W-1:0]   start_idx;
   logic [UIDX_W-1:0]   uop_index_inc;

   // Ready when idle, or when the final uop is being taken this cycle; flush
   // blocks any acceptance.
   always_comb begin
      inst_ready_c = 1'b0;
      if (!flush) begin
         inst_ready_c = (state_q == IDLE) ||
                        ((state_q == SPLIT) && uop_last_q && bus.uop_ready);
      end
   end

   assign accept = bus.inst_valid && inst_ready_c;

   // Clamp the uop count so the index never has to wrap, and derive the last index.
   always_comb begin
      cnt_clamp = bus.inst_uop_cnt;
      if (bus.inst_uop_cnt > 4'(UOP_MAX)) begin
         cnt_clamp = 4'(UOP_MAX);
      end
      last_idx_new  = UIDX_W'(cnt_clamp - 4'd1);
      uop_index_inc = uop_index_q + UIDX_W'(1);
   end

`ifdef UOP_SPLIT_VSTART_SKIP_EN
   localparam int LG_VLENB = $clog2(VLENB);

   logic [1:0]          eew_max;
   logic [VSTART_W-1:0] start_full;

   // First uop that holds at least one body element; saturates at the last uop.
   always_comb begin
      eew_max = bus.inst_vs1_eew;
      if (bus.inst_vs2_eew > eew_max) eew_max = bus.inst_vs2_eew;
      if (bus.inst_vd_eew > eew_max) eew_max = bus.inst_vd_eew;
      if (eew_max > 2'd2) eew_max = 2'd2;
      start_full = bus.inst_vstart >> (LG_VLENB - int'(eew_max));
      if (start_full > VSTART_W'(last_idx_new)) begin
         start_idx = last_idx_new;
      end else begin
         start_idx = start_full[UIDX_W-1:0];
      end
   end
`else
   // Every uop is emitted; prestart bytes are handled downstream.
   assign start_idx = '0;
`endif

   // Next-state: flush first, then acceptance of a new instruction, then uop advance.
   always_comb begin
      state_d          = state_q;
      uop_index_d      = uop_index_q;
      last_idx_d       = last_idx_q;
      uop_last_d       = uop_last_q;
      uop_vl_d         = uop_vl_q;
      uop_vstart_d     = uop_vstart_q;
      uop_vs1_eew_d    = uop_vs1_eew_q;
      uop_vs2_eew_d    = uop_vs2_eew_q;
      uop_vd_eew_d     = uop_vd_eew_q;
      uop_vm_d         = uop_vm_q;
      uop_ignore_vta_d = uop_ignore_vta_q;
      uop_ignore_vma_d = uop_ignore_vma_q;

      if (flush) begin
         state_d    = IDLE;
         uop_last_d = 1'b0;
      end else if (accept) begin
         if ((bus.inst_vl == '0) || (bus.inst_uop_cnt == 4'd0)) begin
            // Empty instruction: consumed without producing a uop.
            state_d    = IDLE;
            uop_last_d = 1'b0;
         end else begin
            state_d          = SPLIT;
            uop_index_d      = start_idx;
            last_idx_d       = last_idx_new;
            uop_last_d       = (start_idx == last_idx_new);
            uop_vl_d         = bus.inst_vl;
            uop_vstart_d     = bus.inst_vstart;
            uop_vs1_eew_d    = bus.inst_vs1_eew;
            uop_vs2_eew_d    = bus.inst_vs2_eew;
            uop_vd_eew_d     = bus.inst_vd_eew;
            uop_vm_d         = bus.inst_vm;
            uop_ignore_vta_d = bus.inst_ignore_vta;
            uop_ignore_vma_d = bus.inst_ignore_vma;
         end
      end else if ((state_q == SPLIT) && bus.uop_ready) begin
         if (uop_last_q) begin
            state_d    = IDLE;
            uop_last_d = 1'b0;
         end else begin
            uop_index_d = uop_index_inc;
            uop_last_d  = (uop_index_inc == last_idx_q);
         end
      end
   end

   // State and output registers; async reset clears everything.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= IDLE;
         uop_index_q      <= '0;
         last_idx_q       <= '0;
         uop_last_q       <= 1'b0;
         uop_vl_q         <= '0;
         uop_vstart_q     <= '0;
         uop_vs1_eew_q    <= '0;
         uop_vs2_eew_q    <= '0;
         uop_vd_eew_q     <= '0;
         uop_vm_q         <= 1'b0;
         uop_ignore_vta_q <= 1'b0;
         uop_ignore_vma_q <= 1'b0;
      end else begin
         state_q          <= state_d;
         uop_index_q      <= uop_index_d;
         last_idx_q       <= last_idx_d;
         uop_last_q       <= uop_last_d;
         uop_vl_q         <= uop_vl_d;
         uop_vstart_q     <= uop_vstart_d;
         uop_vs1_eew_q    <= uop_vs1_eew_d;
         uop_vs2_eew_q    <= uop_vs2_eew_d;
         uop_vd_eew_q     <= uop_vd_eew_d;
         uop_vm_q         <= uop_vm_d;
         uop_ignore_vta_q <= uop_ignore_vta_d;
         uop_ignore_vma_q <= uop_ignore_vma_d;
      end
   end

   assign bus.inst_ready     = inst_ready_c;
   assign bus.uop_valid      = (state_q == SPLIT);
   assign bus.uop_index      = uop_index_q;
   assign bus.uop_last       = uop_last_q;
   assign bus.uop_vl         = uop_vl_q;
   assign bus.uop_vstart     = uop_vstart_q;
   assign bus.uop_vs1_eew    = uop_vs1_eew_q;
   assign bus.uop_vs2_eew    = uop_vs2_eew_q;
   assign bus.uop_vd_eew     = uop_vd_eew_q;
   assign bus.uop_vm         = uop_vm_q;
   assign bus.uop_ignore_vta = uop_ignore_vta_q;
   assign bus.uop_ignore_vma = uop_ignore_vma_q;

endmodule

// File: tb/tb_rvv_backend_uop_split_seq.sv
// Scoreboard bench for rvv_backend_uop_split_seq: directed instructions push
// their expected uops into a queue, a negedge monitor pops and compares every
// accepted uop; directed checks cover reset, ready timing, stalls and flush.
module tb_rvv_backend_uop_split_seq;
   localparam int VL_W     = 8;
   localparam int VSTART_W = 7;
   localparam int UIDX_W   = 3;

   logic clk = 1'b0;
   logic rst;
   logic flush;

   rvv_backend_uop_split_seq_if #(.VL_W(VL_W), .VSTART_W(VSTART_W), .UIDX_W(UIDX_W)) bus ();

   rvv_backend_uop_split_seq #(
      .VLENB(16), .UOP_MAX(8), .VL_W(VL_W), .VSTART_W(VSTART_W), .UIDX_W(UIDX_W)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .flush(flush),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      int idx;
      int last;
      int vl;
      int vstart;
      int e1;
      int e2;
      int ed;
      int vm;
      int vta;
      int vma;
      int cy;
   } exp_t;

   exp_t sb[$];
   exp_t me;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Monitor: every accepted uop is matched against the head of the scoreboard.
   always @(negedge clk) begin
      if (rst === 1'b0 && bus.uop_valid === 1'b1 && bus.uop_ready === 1'b1) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_uop: got index %0d, expected no uop (cycle %0d)",
                     bus.uop_index, cyc);
         end else begin
            me = sb.pop_front();
            chk("uop_index",  32'(bus.uop_index), me.idx);
            chk("uop_last",   32'(bus.uop_last), me.last);
            chk("uop_vl",     32'(bus.uop_vl), me.vl);
            chk("uop_vstart", 32'(bus.uop_vstart), me.vstart);
            chk("uop_eew",    {26'd0, bus.uop_vs1_eew, bus.uop_vs2_eew, bus.uop_vd_eew},
                              (me.e1 << 4) | (me.e2 << 2) | me.ed);
            chk("uop_flags",  {29'd0, bus.uop_vm, bus.uop_ignore_vta, bus.uop_ignore_vma},
                              (me.vm << 2) | (me.vta << 1) | me.vma);
            if (me.cy >= 0) chk("uop_cycle", cyc, me.cy);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(int cnt, int vl, int vst, int e1, int e2, int ed,
                        int vm, int vta, int vma);
      bus.inst_uop_cnt    = 4'(cnt);
      bus.inst_vl         = VL_W'(vl);
      bus.inst_vstart     = VSTART_W'(vst);
      bus.inst_vs1_eew    = 2'(e1);
      bus.inst_vs2_eew    = 2'(e2);
      bus.inst_vd_eew     = 2'(ed);
      bus.inst_vm         = 1'(vm);
      bus.inst_ignore_vta = 1'(vta);
      bus.inst_ignore_vma = 1'(vma);
      bus.inst_valid      = 1'b1;
   endtask

   task automatic push_one(int idx, int last, int vl, int vst, int e1, int e2, int ed,
                           int vm, int vta, int vma, int cy);
      exp_t e;
      e.idx = idx; e.last = last; e.vl = vl; e.vstart = vst;
      e.e1 = e1; e.e2 = e2; e.ed = ed;
      e.vm = vm; e.vta = vta; e.vma = vma; e.cy = cy;
      sb.push_back(e);
   endtask

   // Expected uops start..n-1 with n the clamped count, issued on consecutive cycles.
   task automatic expect_uops(int cnt, int start, int vl, int vst, int e1, int e2, int ed,
                              int vm, int vta, int vma, int first_cy);
      int n;
      n = (cnt > 8) ? 8 : cnt;
      for (int i = start; i < n; i++) begin
         push_one(i, (i == n - 1) ? 1 : 0, vl, vst, e1, e2, ed, vm, vta, vma,
                  (first_cy >= 0) ? first_cy + (i - start) : -1);
      end
   endtask

   int n0;

   initial begin
      rst   = 1'b0;
      flush = 1'b0;
      bus.inst_valid = 1'b0;
      bus.inst_uop_cnt = '0; bus.inst_vl = '0; bus.inst_vstart = '0;
      bus.inst_vs1_eew = '0; bus.inst_vs2_eew = '0; bus.inst_vd_eew = '0;
      bus.inst_vm = 1'b0; bus.inst_ignore_vta = 1'b0; bus.inst_ignore_vma = 1'b0;
      bus.uop_ready = 1'b0;
      #1 rst = 1'b1;

      // reset state
      @(negedge clk);
      chk("rst_uop_valid",  32'(bus.uop_valid), 0);
      chk("rst_uop_last",   32'(bus.uop_last), 0);
      chk("rst_uop_index",  32'(bus.uop_index), 0);
      chk("rst_uop_vl",     32'(bus.uop_vl), 0);
      chk("rst_uop_vstart", 32'(bus.uop_vstart), 0);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_inst_ready", 32'(bus.inst_ready), 1);

      // cnt=4, vl=64, EEW8, ready held high
      step();
      bus.uop_ready = 1'b1;
      offer(4, 64, 0, 0, 0, 0, 1, 0, 0);
      n0 = cyc;
      expect_uops(4, 0, 64, 0, 0, 0, 0, 1, 0, 0, n0 + 1);
      @(negedge clk);
      chk("t1_ready_idle", 32'(bus.inst_ready), 1);
      step();
      bus.inst_valid = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         if (i > 1) step();
         @(negedge clk);
         chk("t1_inst_ready", 32'(bus.inst_ready), (i == 4) ? 1 : 0);
         chk("t1_uop_valid",  32'(bus.uop_valid), 1);
      end
      step();
      @(negedge clk);
      chk("t1_done_valid", 32'(bus.uop_valid), 0);

      // back-to-back: second instruction offered during the first one's last uop
      step();
      offer(3, 48, 5, 1, 1, 1, 0, 1, 0);
      n0 = cyc;
      expect_uops(3, 0, 48, 5, 1, 1, 1, 0, 1, 0, n0 + 1);
      step();
      bus.inst_valid = 1'b0;
      step();
      step();
      offer(2, 20, 0, 0, 1, 2, 1, 1, 1);
      expect_uops(2, 0, 20, 0, 0, 1, 2, 1, 1, 1, cyc + 1);
      @(negedge clk);
      chk("t2_ready_on_last", 32'(bus.inst_ready), 1);
      chk("t2_last_index",    32'(bus.uop_index), 2);
      step();
      bus.inst_valid = 1'b0;
      @(negedge clk);
      chk("t2_b2b_valid", 32'(bus.uop_valid), 1);
      chk("t2_b2b_vl",    32'(bus.uop_vl), 20);
      step();
      step();
      @(negedge clk);
      chk("t2_done_valid", 32'(bus.uop_valid), 0);

      // backpressure at index 1 for 3 cycles
      step();
      offer(4, 64, 0, 1, 1, 1, 1, 0, 0);
      n0 = cyc;
      push_one(0, 0, 64, 0, 1, 1, 1, 1, 0, 0, n0 + 1);
      push_one(1, 0, 64, 0, 1, 1, 1, 1, 0, 0, n0 + 5);
      push_one(2, 0, 64, 0, 1, 1, 1, 1, 0, 0, n0 + 6);
      push_one(3, 1, 64, 0, 1, 1, 1, 1, 0, 0, n0 + 7);
      step();
      bus.inst_valid = 1'b0;
      step();
      bus.uop_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) step();
         @(negedge clk);
         chk("t3_stall_valid", 32'(bus.uop_valid), 1);
         chk("t3_stall_index", 32'(bus.uop_index), 1);
         chk("t3_stall_last",  32'(bus.uop_last), 0);
         chk("t3_stall_vl",    32'(bus.uop_vl), 64);
      end
      step();
      bus.uop_ready = 1'b1;
      step();
      step();
      step();
      @(negedge clk);
      chk("t3_done_valid", 32'(bus.uop_valid), 0);

      // vl=0, cnt=8: consumed, no uop
      step();
      offer(8, 0, 0, 0, 0, 0, 1, 0, 0);
      @(negedge clk);
      chk("t4_ready", 32'(bus.inst_ready), 1);
      for (int k = 0; k < 3; k++) begin
         step();
         bus.inst_valid = 1'b0;
         @(negedge clk);
         chk("t4_no_uop",   32'(bus.uop_valid), 0);
         chk("t4_idle_rdy", 32'(bus.inst_ready), 1);
      end

      // flush at index 2 of cnt=8 while another instruction is offered
      step();
      offer(8, 128, 0, 0, 0, 0, 1, 0, 0);
      n0 = cyc;
      push_one(0, 0, 128, 0, 0, 0, 0, 1, 0, 0, n0 + 1);
      push_one(1, 0, 128, 0, 0, 0, 0, 1, 0, 0, n0 + 2);
      step();
      bus.inst_valid = 1'b0;
      step();
      step();
      flush = 1'b1;
      bus.uop_ready = 1'b0;
      offer(2, 10, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("t5_flush_index", 32'(bus.uop_index), 2);
      chk("t5_flush_ready", 32'(bus.inst_ready), 0);
      step();
      flush = 1'b0;
      bus.inst_valid = 1'b0;
      bus.uop_ready = 1'b1;
      @(negedge clk);
      chk("t5_after_valid", 32'(bus.uop_valid), 0);
      chk("t5_after_ready", 32'(bus.inst_ready), 1);
      step();
      @(negedge clk);
      chk("t5_not_accepted", 32'(bus.uop_valid), 0);

      // vstart=40, EEW32 everywhere, cnt=8
      step();
      offer(8, 64, 40, 2, 2, 2, 1, 0, 0);
      n0 = cyc;
`ifdef UOP_SPLIT_VSTART_SKIP_EN
      expect_uops(8, 7, 64, 40, 2, 2, 2, 1, 0, 0, n0 + 1);
`else
      expect_uops(8, 0, 64, 40, 2, 2, 2, 1, 0, 0, n0 + 1);
`endif
      step();
      bus.inst_valid = 1'b0;
      @(negedge clk);
`ifdef UOP_SPLIT_VSTART_SKIP_EN
      chk("t6_first_index", 32'(bus.uop_index), 7);
      chk("t6_first_last",  32'(bus.uop_last), 1);
`else
      chk("t6_first_index", 32'(bus.uop_index), 0);
      chk("t6_first_last",  32'(bus.uop_last), 0);
`endif
      repeat (8) step();
      @(negedge clk);
      chk("t6_done_valid", 32'(bus.uop_valid), 0);

      // vstart=40, widest EEW16 (8 elements per uop)
      step();
      offer(8, 64, 40, 0, 1, 0, 0, 1, 1);
      n0 = cyc;
`ifdef UOP_SPLIT_VSTART_SKIP_EN
      expect_uops(8, 5, 64, 40, 0, 1, 0, 0, 1, 1, n0 + 1);
`else
      expect_uops(8, 0, 64, 40, 0, 1, 0, 0, 1, 1, n0 + 1);
`endif
      step();
      bus.inst_valid = 1'b0;
      repeat (8) step();

      // cnt=12 clamps to 8 uops
      offer(12, 100, 0, 0, 1, 0, 0, 0, 1);
      n0 = cyc;
      expect_uops(12, 0, 100, 0, 0, 1, 0, 0, 0, 1, n0 + 1);
      step();
      bus.inst_valid = 1'b0;
      repeat (8) step();
      @(negedge clk);
      chk("t7_done_valid", 32'(bus.uop_valid), 0);

      repeat (4) step();
      @(negedge clk);
      chk("sb_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/rvv_backend_uop_split_seq.md
# rvv_backend_uop_split_seq

Sequential uop splitter in the RVV backend dispatch path, directly upstream of the operand byte-type generator. Accepts one decoded vector instruction per handshake and emits its uops one per cycle, each carrying `uop_index`, `uop_last` and the per-instruction fields the byte-type generator needs. Holds outputs stable under downstream backpressure, supports back-to-back instructions without a bubble, and honours a trap flush.

## Interface
Parameters:
- `VLENB`, 16: bytes per vector register.
- `UOP_MAX`, 8: maximum uops per instruction (LMUL 8).
- `VL_W`, 8: width of vl (holds 0..128).
- `VSTART_W`, 7: width of vstart.
- `UIDX_W`, 3: uop index width, `$clog2(UOP_MAX)`.

Ports (clock is `clk`; reset is `rst`, asynchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: async active-high reset.
- `flush` in 1: synchronous trap flush.
- `inst_valid` in 1: instruction available.
- `inst_ready` out 1: splitter can accept.
- `inst_uop_cnt` in 4: uop count, 0..8.
- `inst_vl` in VL_W: vl.
- `inst_vstart` in VSTART_W: vstart.
- `inst_vs1_eew`, `inst_vs2_eew`, `inst_vd_eew` in 2 each: EEW_e codes (EEW8/16/32).
- `inst_vm`, `inst_ignore_vta`, `inst_ignore_vma` in 1 each: mask and policy flags.
- `uop_valid` out 1: uop presented.
- `uop_ready` in 1: downstream accepts.
- `uop_index` out UIDX_W: uop index.
- `uop_last` out 1: final uop of the instruction.
- `uop_vl`, `uop_vstart`, `uop_vs1_eew`, `uop_vs2_eew`, `uop_vd_eew`, `uop_vm`, `uop_ignore_vta`, `uop_ignore_vma` out: latched instruction fields.

## Operation
- States: IDLE, SPLIT. Reset and flush go to IDLE.
- `inst_ready` = IDLE, or (SPLIT and `uop_valid & uop_ready & uop_last`). Combinational, not dependent on `inst_valid`.
- Accept (`inst_valid & inst_ready & !flush`):
  - If `inst_vl==0` or `inst_uop_cnt==0`: instruction consumed, no uop emitted, next state IDLE.
  - Else: latch fields, set `uop_index` = start index (0 by default), `last_idx` = `inst_uop_cnt-1`, next state SPLIT.
- SPLIT: `uop_valid=1`; `uop_last = (uop_index==last_idx)`.
  - `uop_ready=0`: all uop outputs held unchanged.
  - `uop_ready=1`, not last: `uop_index` increments by 1.
  - `uop_ready=1`, last: accept a new instruction in the same cycle if offered (stays SPLIT, new fields next cycle); otherwise IDLE.
- `uop_index` never wraps: `last_idx` ≤ UOP_MAX-1. `inst_uop_cnt` > UOP_MAX is clamped to UOP_MAX.
- `flush` has priority over every handshake in the same cycle: the current uop is dropped, the offered instruction is not accepted (`inst_ready` forced 0), next state IDLE.

## Timing
- Reset values: state IDLE, `uop_valid=0`, `uop_last=0`, `uop_index=0`, all latched fields 0; `inst_ready=1` after reset deassertion.
- Latency: an instruction accepted in cycle N presents its first uop in cycle N+1.
- Throughput: one uop per cycle. No idle cycle between the last uop of one instruction and the first uop of the next.
- An async `rst` asserted mid-instruction clears state immediately; there is no partial replay.
- All outputs except `inst_ready` are registered.

## Configuration
- `UOP_SPLIT_VSTART_SKIP_EN` defined: uops lying entirely in the prestart region are not emitted.
  - `eew_max` = the widest of vs1/vs2/vd EEW.
  - Elements per uop = `VLENB>>log2(eew_max/8)`.
  - Start index = `inst_vstart / elements_per_uop`, saturated at `last_idx`.
- Not defined: the start index is always 0 and every uop is emitted. Prestart bytes are then marked NOT_CHANGE downstream.

## Test plan
- cnt=4, vl=64, EEW8 all operands, `uop_ready` held 1 → uops with index 0,1,2,3 in cycles N+1..N+4, `uop_last` only at index 3; `inst_ready` high at N+4 and low at N+1..N+3.
- Back-to-back: second instruction (cnt=2) offered during the first one's last uop with `uop_ready=1` → accepted that cycle; next cycles show index 0,1 with no bubble and the new vl.
- Backpressure: `uop_ready` low for 3 cycles at index 1 → index, fields and `uop_valid` stable for those 3 cycles; resumes at index 2.
- vl=0, cnt=8 → consumed in 1 cycle, `uop_valid` never asserted, state stays IDLE.
- `flush` asserted at index 2 of cnt=8 while `inst_valid=1` → next cycle `uop_valid=0`, IDLE; offered instruction not accepted (`inst_ready` was 0 that cycle).
- With `UOP_SPLIT_VSTART_SKIP_EN`: vstart=40, EEW32/EEW32/EEW32, cnt=8 (4 elements per uop) → first uop index 7 with `uop_last=1`. Without the macro, first uop index 0.
